// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared types and constants for the RAM readout engine
package mem_dump_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

   function automatic int bytes_of(input int dw);
      return dw / 8;
   endfunction

   localparam int BYTES_PER_WORD = bytes_of(DEF_DATA_W);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      SEND,
      FINISH
   } dump_state_t;
endpackage

// File: rtl/mem_dump_if.sv
// mem_dump_if: control, RAM read port and byte stream of the readout engine
interface mem_dump_if #(
   parameter int ADDR_W = mem_dump_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem_dump_pkg::DEF_DATA_W
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] word_count;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rden;
   logic [DATA_W-1:0] mem_q;
   logic [7:0]        byte_out;
   logic              byte_valid;
   logic              byte_ready;
   logic              busy;
   logic              done;

   modport slave (
      input  start, base_addr, word_count, mem_q, byte_ready,
      output mem_addr, mem_rden, byte_out, byte_valid, busy, done
   );

   modport master (
      output start, base_addr, word_count, mem_q, byte_ready,
      input  mem_addr, mem_rden, byte_out, byte_valid, busy, done
   );
endinterface

// File: rtl/mem_dump_unit_serializer.sv
// word_serializer: parallel-load word, emit bytes MSB first over valid/ready
module word_serializer
   import mem_dump_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic [7:0]        o_byte,
   output logic              o_valid,
   output logic              o_last
);
   localparam int NB = bytes_of(DATA_W);
   localparam int CW = NB > 1 ? $clog2(NB) : 1;

   logic [DATA_W-1:0] r_data;
   logic [CW-1:0]     r_cnt;
   logic              r_valid;
   logic              w_fire;

   assign w_fire  = r_valid && i_ready;
   assign o_last  = r_cnt == CW'(NB - 1);
   assign o_byte  = r_data[DATA_W-1 -: 8];
   assign o_valid = r_valid;

   // Hold the current byte until accepted, then shift the next one to the top
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_cnt   <= '0;
         r_valid <= 1'b1;
      end else if (w_fire) begin
         r_data  <= r_data << 8;
         r_cnt   <= r_cnt + 1'b1;
         r_valid <= !o_last;
      end
   end
endmodule

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: read a window of RAM words and stream them out as bytes
module mem_dump_unit
   import mem_dump_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = 1
) (
   input logic       clk,
   input logic       rst,
   mem_dump_if.slave bus
);
   localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

   dump_state_t       r_state;
   dump_state_t       w_state_nxt;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] w_base_nxt;
   logic [ADDR_W-1:0] w_count_nxt;
   logic [ADDR_W-1:0] w_idx_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [LW-1:0]     r_lat;
   logic              r_mem_rden;
   logic              r_busy;
   logic              r_done;
   logic              w_rden_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic              w_accept;
   logic              w_lat_done;
   logic              w_word_done;
   logic              w_last;
   logic              w_valid;
   logic [7:0]        w_byte;

   assign w_accept    = r_state == IDLE && bus.start;
   assign w_lat_done  = r_state == WAIT && r_lat == LW'(RD_LAT - 1);
   assign w_word_done = r_state == SEND && w_valid && bus.byte_ready && w_last;

   word_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_lat_done),
      .i_data  (bus.mem_q),
      .i_ready (bus.byte_ready),
      .o_byte  (w_byte),
      .o_valid (w_valid),
      .o_last  (w_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state plus the next values of the latched job and the word index
   always_comb begin
      w_base_nxt  = w_accept ? bus.base_addr : r_base;
      w_count_nxt = w_accept ? bus.word_count : r_count;
      w_idx_nxt   = w_accept ? '0 : w_word_done ? r_idx + 1'b1 : r_idx;
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = bus.word_count == '0 ? FINISH : ISSUE;
         ISSUE:   w_state_nxt = WAIT;
         WAIT:    if (w_lat_done) w_state_nxt = SEND;
         SEND:    if (w_word_done) w_state_nxt = w_idx_nxt == r_count ? FINISH : ISSUE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they can be registered with no lag
   always_comb begin
      w_rden_nxt = w_state_nxt == ISSUE;
      w_addr_nxt = w_rden_nxt ? w_base_nxt + w_idx_nxt : r_mem_addr;
      w_busy_nxt = w_state_nxt != IDLE;
      w_done_nxt = w_state_nxt == FINISH;
   end

   // Job registers, latency counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base     <= '0;
         r_count    <= '0;
         r_idx      <= '0;
         r_lat      <= '0;
         r_mem_addr <= '0;
         r_mem_rden <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_base     <= w_base_nxt;
         r_count    <= w_count_nxt;
         r_idx      <= w_idx_nxt;
         r_lat      <= r_state == WAIT ? r_lat + 1'b1 : '0;
         r_mem_addr <= w_addr_nxt;
         r_mem_rden <= w_rden_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_rden   = r_mem_rden;
   assign bus.byte_out   = w_byte;
   assign bus.byte_valid = w_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Post-run readout engine for the processor's data RAM. After the pipeline finishes a program, `mem_dump_unit` reads a contiguous window of 32-bit words from the RAM read port and streams them out as bytes over a valid/ready handshake toward the board's output link. It is the reader counterpart of the datapath's MEM-stage store path: the processor writes results, and this block drains them.

## Interface
Parameters:
- `ADDR_W`, 16, RAM word-address width.
- `DATA_W`, 32, RAM word width; must be a multiple of 8.
- `RD_LAT`, 1, RAM read latency in `clk` cycles from the address being presented to `mem_q` being valid.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; latched on an accepted `start`.
- `word_count`  in  ADDR_W  number of words to dump; latched on an accepted `start`.
- `mem_addr`  out  ADDR_W  RAM read address.
- `mem_rden`  out  1  read strobe, one cycle per word.
- `mem_q`  in  DATA_W  RAM read data.
- `byte_out`  out  8  output byte.
- `byte_valid`  out  1  `byte_out` is valid.
- `byte_ready`  in  1  downstream accepts the byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- FSM states: IDLE, ISSUE, WAIT, SEND, FINISH.
- IDLE:
  - If `start`=1, latch `base_addr` and `word_count` and clear the word index `idx`.
  - If the latched count is 0, go to FINISH; otherwise go to ISSUE.
- ISSUE:
  - Drive `mem_addr` = (base + idx) mod 2^ADDR_W and `mem_rden`=1 for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - Count `RD_LAT` cycles.
  - On the cycle `mem_q` is valid, load it into the serializer and go to SEND.
- SEND:
  - Send DATA_W/8 bytes, most significant byte first, one byte per handshake (`byte_valid` && `byte_ready`).
  - After the last byte, increment `idx`. Go to FINISH if `idx` equals the count; otherwise go to ISSUE.
- FINISH: assert `done` for one cycle, then go to IDLE.
- Handshake rules:
  - While `byte_valid`=1 and `byte_ready`=0, `byte_out` holds stable.
  - `byte_valid` never drops before a transfer completes.
  - `byte_valid` is never asserted outside SEND.
- `start` while `busy`=1 is ignored and not queued.
- Address wrap-around is silent: base 0xFFFF with count 2 reads 0xFFFF, then 0x0000.
- `word_count` of 0xFFFF is legal and is not treated as special.
- Reset in any state:
  - Next state is IDLE, with `idx` and the serializer cleared.
  - `byte_valid`, `mem_rden`, `busy` and `done` are 0 on the cycle after `rst` is sampled.
  - No `done` is produced for an aborted dump.
- `rst` has priority over `start` in the same cycle.

## Timing
- Reset values: `mem_addr`=0, `mem_rden`=0, `byte_out`=0x00, `byte_valid`=0, `busy`=0, `done`=0.
- All outputs are registered.
- Cycle 0: `start` is accepted. Cycle 1: ISSUE, so `mem_rden`=1. Cycle 1+RD_LAT+1: first `byte_valid`=1.
- With `byte_ready` held high, each word takes 1 (ISSUE) + RD_LAT (WAIT) + 4 (SEND) cycles. With RD_LAT=1, that is 6 cycles per word.
- `done` rises the cycle after the last byte handshake.
- `busy` falls together with `done`; that is, `busy`=0 on the cycle after `done`=1 is not required.
- For `word_count`=0, `done` pulses on cycle 1 after the accepted `start`, with no RAM access.

## Structure
- Package `mem_dump_pkg` holds:
  - the `dump_state_t` enum (IDLE, ISSUE, WAIT, SEND, FINISH);
  - `BYTES_PER_WORD` = DATA_W/8;
  - the default `ADDR_W`/`DATA_W` constants shared with the RAM wrapper.
- Sub-module `word_serializer`:
  - parallel-load, MSB-first, valid/ready byte shifter;
  - outputs `last_byte` to the FSM.
- The top module holds the FSM, the index counter and the address adder.

## Test plan
- Preload RAM[0x10]=0xDEADBEEF and RAM[0x11]=0x01020304. Run `start` with base 0x10, count 2 and `byte_ready`=1. Required: bytes DE AD BE EF 01 02 03 04, one `done` pulse 13 cycles after `start`.
- `word_count`=0: `done` on cycle 1, `mem_rden` never asserted, `byte_valid` never asserted.
- Toggle `byte_ready` 1/0 randomly during a 3-word dump. Required: byte sequence unchanged, `byte_out` stable during stalls, no byte duplicated or lost.
- Base 0xFFFF, count 2: `mem_addr` sequence 0xFFFF, 0x0000.
- Pulse `start` again mid-dump: no effect on the stream. Then assert `rst` during SEND of word 1: next cycle all outputs are at reset values and no `done` is produced. A subsequent `start` runs cleanly from the new base.
- RD_LAT=2 build: the correct word is captured, with per-word spacing of 7 cycles.
